// File: rtl/noise_voice_ext.sv
// noise_voice_ext: single-clock noise voice for the stereo voice bank.
// A programmable-tap Fibonacci LFSR is stepped from a prescaled period divider.
// Its output is shaped by a key-gated ADSR envelope, then scaled and panned
// through a three-stage pipeline that produces one stereo sample per tick_sample.
// Ports:
//   clk_50mhz, reset_n          clock, asynchronous active-low reset
//   tick_sample, tick_env       one-cycle timing strobes (48 kHz / 8 kHz)
//   key_on                      gate level (rise = attack, fall = release)
//   period, tap_mask            LFSR step rate and feedback taps
//   seed_load, seed             LFSR seed load
//   amp_mode                    0 = binary +/-AMP, 1 = multi-level
//   atk/dcy/rel_rate, sus_lvl   envelope rates and sustain level
//   pan                         0 = full left .. 31 = almost full right
//   audio_l/r, sample_valid     registered stereo output and its strobe
//   env_state, env_level        envelope state and level
//   lfsr_state                  LFSR contents
module noise_voice_ext #(
    parameter int unsigned LFSR_W   = 23,
    parameter int unsigned PERIOD_W = 12,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned VOL_W    = 6,
    parameter int unsigned PRESCALE = 28
) (
    input  logic                    clk_50mhz,
    input  logic                    reset_n,
    input  logic                    tick_sample,
    input  logic                    tick_env,
    input  logic                    key_on,
    input  logic [PERIOD_W-1:0]     period,
    input  logic [LFSR_W-1:0]       tap_mask,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed,
    input  logic                    amp_mode,
    input  logic [3:0]              atk_rate,
    input  logic [3:0]              dcy_rate,
    input  logic [3:0]              rel_rate,
    input  logic [VOL_W-1:0]        sus_lvl,
    input  logic [4:0]              pan,
    output logic signed [OUT_W-1:0] audio_l,
    output logic signed [OUT_W-1:0] audio_r,
    output logic                    sample_valid,
    output logic [2:0]              env_state,
    output logic [VOL_W-1:0]        env_level,
    output logic [LFSR_W-1:0]       lfsr_state
);

    localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned ICNT_W = 6;
    localparam int unsigned P1_W   = OUT_W + VOL_W + 1;
    localparam int unsigned P2_W   = OUT_W + 7;
    localparam logic [VOL_W-1:0]        LVL_MAX  = '1;
    localparam logic signed [OUT_W-1:0] AMP      = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] NEG_AMP  = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]        MIN_CODE = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    // ---------------- LFSR and period divider ----------------
    logic [PRE_W-1:0]    pre_cnt;
    logic [PERIOD_W-1:0] per_cnt;
    logic [LFSR_W-1:0]   lfsr;
    logic                pre_tick_c;
    logic                step_c;
    logic [LFSR_W-1:0]   lfsr_step_c;

    assign pre_tick_c  = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign step_c      = pre_tick_c && (per_cnt == period);
    assign lfsr_step_c = {^(lfsr & tap_mask), lfsr[LFSR_W-1:1]};

    // Seed load outranks a same-cycle step; the all-zero state is never entered.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            lfsr    <= LFSR_W'(1);
            pre_cnt <= '0;
            per_cnt <= '0;
        end else if (seed_load) begin
            lfsr    <= (seed == '0) ? LFSR_W'(1) : seed;
            pre_cnt <= '0;
            per_cnt <= '0;
        end else begin
            pre_cnt <= pre_tick_c ? '0 : pre_cnt + PRE_W'(1);
            if (pre_tick_c) begin
                per_cnt <= step_c ? '0 : per_cnt + PERIOD_W'(1);
            end
            if (step_c) begin
                lfsr <= (lfsr_step_c == '0) ? LFSR_W'(1) : lfsr_step_c;
            end
        end
    end

    // ---------------- Envelope FSM ----------------
    env_state_t          state, state_nxt;
    logic [VOL_W-1:0]    level, level_nxt;
    logic [ICNT_W-1:0]   icnt, icnt_nxt;
    logic                key_q;
    logic                rise_c, fall_c, active_c, edge_act_c, counting_c;
    logic [3:0]          rate_sel_c;
    logic [ICNT_W-1:0]   limit_c;
    logic                ivl_done_c;

    assign rise_c     = key_on & ~key_q;
    assign fall_c     = ~key_on & key_q;
    assign active_c   = (state == ST_ATTACK) || (state == ST_DECAY) || (state == ST_SUSTAIN);
    assign edge_act_c = rise_c || (fall_c && active_c);
    assign counting_c = (state == ST_ATTACK) || (state == ST_DECAY) || (state == ST_RELEASE);

    always_comb begin
        rate_sel_c = atk_rate;
        case (state)
            ST_DECAY:   rate_sel_c = dcy_rate;
            ST_RELEASE: rate_sel_c = rel_rate;
            default:    rate_sel_c = atk_rate;
        endcase
    end

    // Interval of 4*(rate+1) pulses ends when the counter reaches 4*rate+3.
    assign limit_c    = {rate_sel_c, 2'b11};
    assign ivl_done_c = tick_env && (icnt == limit_c);

    // State register
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            level <= '0;
            icnt  <= '0;
            key_q <= 1'b0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            icnt  <= icnt_nxt;
            key_q <= key_on;
        end
    end

    // Next state: key edges first, then tick_env-driven progress
    always_comb begin
        state_nxt = state;
        if (rise_c) begin
            state_nxt = ST_ATTACK;
        end else if (fall_c && active_c) begin
            state_nxt = ST_RELEASE;
        end else if (tick_env) begin
            case (state)
                ST_ATTACK: begin
                    if (level == LVL_MAX || (ivl_done_c && level == LVL_MAX - VOL_W'(1)))
                        state_nxt = ST_DECAY;
                end
                ST_DECAY: begin
                    if (level <= sus_lvl || (ivl_done_c && (level - VOL_W'(1)) <= sus_lvl))
                        state_nxt = ST_SUSTAIN;
                end
                ST_RELEASE: begin
                    if (level == '0 || (ivl_done_c && level == VOL_W'(1)))
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Level and interval counter; any transition or retrigger restarts the interval
    always_comb begin
        level_nxt = level;
        icnt_nxt  = icnt;
        if (!edge_act_c && tick_env && counting_c) begin
            icnt_nxt = ivl_done_c ? '0 : icnt + ICNT_W'(1);
            if (ivl_done_c) begin
                case (state)
                    ST_ATTACK:  if (level != LVL_MAX) level_nxt = level + VOL_W'(1);
                    ST_DECAY:   if (level > sus_lvl)  level_nxt = level - VOL_W'(1);
                    ST_RELEASE: if (level != '0)      level_nxt = level - VOL_W'(1);
                    default:    level_nxt = level;
                endcase
            end
        end
        if (edge_act_c || (state_nxt != state)) begin
            icnt_nxt = '0;
        end
    end

    // ---------------- Output pipeline ----------------
    logic signed [OUT_W-1:0] sample_c;
    logic                    v1, v2;
    logic signed [OUT_W-1:0] s1_sample;
    logic [VOL_W-1:0]        s1_level;
    logic [4:0]              s1_pan;
    logic signed [OUT_W-1:0] s2_scaled;
    logic [4:0]              s2_pan;
    logic signed [P1_W-1:0]  prod1_c;
    logic [5:0]              pan_l_c;
    logic signed [P2_W-1:0]  prod_l_c, prod_r_c;

    always_comb begin
        if (amp_mode) begin
            sample_c = (lfsr[OUT_W-1:0] == MIN_CODE) ? NEG_AMP : $signed(lfsr[OUT_W-1:0]);
        end else begin
            sample_c = lfsr[0] ? AMP : NEG_AMP;
        end
    end

    assign prod1_c  = $signed({{(VOL_W+1){s1_sample[OUT_W-1]}}, s1_sample})
                    * $signed({{(OUT_W+1){1'b0}}, s1_level});
    assign pan_l_c  = 6'd32 - {1'b0, s2_pan};
    assign prod_l_c = $signed({{7{s2_scaled[OUT_W-1]}}, s2_scaled})
                    * $signed({{(OUT_W+1){1'b0}}, pan_l_c});
    assign prod_r_c = $signed({{7{s2_scaled[OUT_W-1]}}, s2_scaled})
                    * $signed({{(OUT_W+2){1'b0}}, s2_pan});

    // Pan travels with its sample so mid-flight pan changes cannot tear a result
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            s1_sample    <= '0;
            s1_level     <= '0;
            s1_pan       <= '0;
            s2_scaled    <= '0;
            s2_pan       <= '0;
            audio_l      <= '0;
            audio_r      <= '0;
            sample_valid <= 1'b0;
        end else begin
            v1           <= tick_sample;
            v2           <= v1;
            sample_valid <= v2;
            if (tick_sample) begin
                s1_sample <= sample_c;
                s1_level  <= level;
                s1_pan    <= pan;
            end
            if (v1) begin
                s2_scaled <= OUT_W'(prod1_c >>> VOL_W);
                s2_pan    <= s1_pan;
            end
            if (v2) begin
                audio_l <= OUT_W'(prod_l_c >>> 5);
                audio_r <= OUT_W'(prod_r_c >>> 5);
            end
        end
    end

    assign env_state  = state;
    assign env_level  = level;
    assign lfsr_state = lfsr;

endmodule

// File: tb/tb_noise_voice_ext.sv
// Self-checking bench for noise_voice_ext: directed checks with literal values,
// then randomized stimulus compared every cycle against a behavioural model.
module tb_noise_voice_ext;

    localparam int PRESCALE = 28;

    logic               clk_50mhz = 1'b0;
    logic               reset_n;
    logic               tick_sample, tick_env, key_on, seed_load, amp_mode;
    logic [11:0]        period;
    logic [22:0]        tap_mask, seed;
    logic [3:0]         atk_rate, dcy_rate, rel_rate;
    logic [5:0]         sus_lvl;
    logic [4:0]         pan;
    logic signed [15:0] audio_l, audio_r;
    logic               sample_valid;
    logic [2:0]         env_state;
    logic [5:0]         env_level;
    logic [22:0]        lfsr_state;

    always #5 clk_50mhz = ~clk_50mhz;

    noise_voice_ext dut (
        .clk_50mhz(clk_50mhz), .reset_n(reset_n),
        .tick_sample(tick_sample), .tick_env(tick_env), .key_on(key_on),
        .period(period), .tap_mask(tap_mask), .seed_load(seed_load), .seed(seed),
        .amp_mode(amp_mode), .atk_rate(atk_rate), .dcy_rate(dcy_rate), .rel_rate(rel_rate),
        .sus_lvl(sus_lvl), .pan(pan),
        .audio_l(audio_l), .audio_r(audio_r), .sample_valid(sample_valid),
        .env_state(env_state), .env_level(env_level), .lfsr_state(lfsr_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; int l; int r; } exp_t;
    exp_t        q[$];
    logic [22:0] m_lfsr;
    int          m_pre, m_per, m_st, m_lvl, m_cnt, m_cyc, m_al, m_ar;
    bit          m_key, m_vexp;

    function automatic logic [22:0] lfsr_next(input logic [22:0] v, input logic [22:0] m);
        logic [22:0] n;
        n = (v >> 1) | (23'($countones(v & m) % 2) << 22);
        if (n == 23'd0) n = 23'd1;
        return n;
    endfunction

    function automatic int sample_of(input logic [22:0] v, input bit mode);
        int s;
        if (!mode) return v[0] ? 32767 : -32767;
        s = int'($signed(v[15:0]));
        if (s == -32768) s = -32767;
        return s;
    endfunction

    always @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            m_lfsr = 23'd1; m_pre = 0; m_per = 0;
            m_st = 0; m_lvl = 0; m_cnt = 0; m_key = 0;
            q.delete(); m_al = 0; m_ar = 0; m_vexp = 0; m_cyc = 0;
        end else begin
            bit rise, fall;
            int ival, sus;
            m_cyc++;
            if (tick_sample) begin
                int s, sc, p;
                p  = int'(pan);
                s  = sample_of(m_lfsr, amp_mode);
                sc = (s * m_lvl) >>> 6;
                q.push_back('{m_cyc + 2, (sc * (32 - p)) >>> 5, (sc * p) >>> 5});
            end
            m_vexp = 0;
            if (q.size() > 0 && q[0].due == m_cyc) begin
                m_al = q[0].l; m_ar = q[0].r; m_vexp = 1;
                void'(q.pop_front());
            end
            if (seed_load) begin
                m_lfsr = (seed == 23'd0) ? 23'd1 : seed;
                m_pre = 0; m_per = 0;
            end else if (m_pre == PRESCALE - 1) begin
                m_pre = 0;
                if (m_per == int'(period)) begin
                    m_per = 0;
                    m_lfsr = lfsr_next(m_lfsr, tap_mask);
                end else begin
                    m_per = (m_per + 1) % 4096;
                end
            end else begin
                m_pre++;
            end
            rise = key_on && !m_key;
            fall = !key_on && m_key;
            m_key = key_on;
            sus = int'(sus_lvl);
            if (rise) begin
                m_st = 1; m_cnt = 0;
            end else if (fall && m_st >= 1 && m_st <= 3) begin
                m_st = 4; m_cnt = 0;
            end else if (tick_env) begin
                case (m_st)
                    1: begin
                        ival = 4 * (int'(atk_rate) + 1);
                        if (m_lvl == 63) begin m_st = 2; m_cnt = 0; end
                        else begin
                            m_cnt++;
                            if (m_cnt == ival) begin
                                m_cnt = 0; m_lvl++;
                                if (m_lvl == 63) m_st = 2;
                            end
                        end
                    end
                    2: begin
                        ival = 4 * (int'(dcy_rate) + 1);
                        if (m_lvl <= sus) begin m_st = 3; m_cnt = 0; end
                        else begin
                            m_cnt++;
                            if (m_cnt == ival) begin
                                m_cnt = 0; m_lvl--;
                                if (m_lvl <= sus) m_st = 3;
                            end
                        end
                    end
                    4: begin
                        ival = 4 * (int'(rel_rate) + 1);
                        if (m_lvl == 0) begin m_st = 0; m_cnt = 0; end
                        else begin
                            m_cnt++;
                            if (m_cnt == ival) begin
                                m_cnt = 0; m_lvl--;
                                if (m_lvl == 0) m_st = 0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk_50mhz) begin
        if (reset_n === 1'b1) begin
            check("lfsr_state",   lfsr_state,        m_lfsr);
            check("env_state",    env_state,         m_st);
            check("env_level",    env_level,         m_lvl);
            check("sample_valid", sample_valid,      m_vexp);
            check("audio_l",      $signed(audio_l),  m_al);
            check("audio_r",      $signed(audio_r),  m_ar);
        end
    end

    // ---------------- stimulus ----------------
    task automatic nclk(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    task automatic pulse_env(input int n);
        repeat (n) begin
            tick_env = 1'b1; nclk(1);
            tick_env = 1'b0; nclk(1);
        end
    endtask

    // One sample through the pipeline; valid must appear exactly on the third edge
    task automatic sample_and_check(input int exp_l, input int exp_r);
        tick_sample = 1'b1; nclk(1);
        tick_sample = 1'b0;
        check("valid_lat1", sample_valid, 1'b0);
        nclk(1);
        check("valid_lat2", sample_valid, 1'b0);
        nclk(1);
        check("valid_lat3", sample_valid, 1'b1);
        check("lit_audio_l", $signed(audio_l), exp_l);
        check("lit_audio_r", $signed(audio_r), exp_r);
        nclk(1);
        check("valid_drop", sample_valid, 1'b0);
        check("hold_audio_l", $signed(audio_l), exp_l);
    endtask

    initial begin
        int since_tick;
        reset_n = 1'b0; tick_sample = 0; tick_env = 0; key_on = 0; seed_load = 0;
        seed = '0; amp_mode = 0; period = '0; tap_mask = 23'h000021;
        atk_rate = 0; dcy_rate = 0; rel_rate = 0; sus_lvl = 6'd32; pan = '0;
        nclk(2);
        reset_n = 1'b1;
        check("rst_lfsr",  lfsr_state, 23'h000001);
        check("rst_state", env_state, 3'd0);
        check("rst_level", env_level, 6'd0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_audio", $signed(audio_l), 0);

        // LFSR stepping with period 0: one step per 28 cycles
        nclk(27);
        check("lfsr_pre_step", lfsr_state, 23'h000001);
        nclk(1);
        check("lfsr_step1", lfsr_state, 23'h400000);
        nclk(28);
        check("lfsr_step2", lfsr_state, 23'h200000);

        // Zero seed and zero taps must never lock the LFSR at 0
        seed_load = 1; seed = '0; tap_mask = '0; nclk(1);
        seed_load = 0;
        check("seed0_lfsr", lfsr_state, 23'h000001);
        nclk(28 * 3);
        check("guard_lfsr", lfsr_state, 23'h000001);

        // Envelope attack to MAX with a slow LFSR and lfsr[0]=1
        seed_load = 1; seed = 23'd1; period = 12'd4095; tap_mask = 23'h000021; nclk(1);
        seed_load = 0;
        key_on = 1; nclk(1);
        check("atk_state", env_state, 3'd1);
        check("atk_level0", env_level, 6'd0);
        pulse_env(251);
        check("atk_level62", env_level, 6'd62);
        pulse_env(1);
        check("atk_level63", env_level, 6'd63);
        check("decay_state", env_state, 3'd2);

        // Amplitude, volume and pan arithmetic
        amp_mode = 0; pan = 5'd0;
        sample_and_check(32255, 0);
        pan = 5'd16;
        sample_and_check(16127, 16127);
        seed_load = 1; seed = 23'd2; nclk(1);
        seed_load = 0; pan = 5'd0;
        sample_and_check(-32256, 0);

        // Decay to sustain, then release to idle
        pulse_env(123);
        check("decay_level33", env_level, 6'd33);
        pulse_env(1);
        check("sus_state", env_state, 3'd3);
        check("sus_level", env_level, 6'd32);
        pulse_env(8);
        check("sus_hold", env_level, 6'd32);
        key_on = 0; nclk(1);
        check("rel_state", env_state, 3'd4);
        pulse_env(128);
        check("idle_state", env_state, 3'd0);
        check("idle_level", env_level, 6'd0);

        // Retrigger during release keeps the level
        key_on = 1; nclk(1);
        pulse_env(100);
        check("atk_level25", env_level, 6'd25);
        key_on = 0; nclk(1);
        pulse_env(20);
        check("rel_level20", env_level, 6'd20);
        key_on = 1; nclk(1);
        check("retrig_state", env_state, 3'd1);
        check("retrig_level", env_level, 6'd20);
        pulse_env(3);
        check("retrig_hold", env_level, 6'd20);
        pulse_env(1);
        check("retrig_step", env_level, 6'd21);

        // Asynchronous reset mid-attack with a sample in flight
        tick_sample = 1; nclk(1);
        tick_sample = 0;
        #2 reset_n = 1'b0;
        #1;
        check("async_audio_l", $signed(audio_l), 0);
        check("async_audio_r", $signed(audio_r), 0);
        check("async_valid", sample_valid, 1'b0);
        check("async_state", env_state, 3'd0);
        check("async_level", env_level, 6'd0);
        check("async_lfsr", lfsr_state, 23'h000001);
        nclk(2);
        reset_n = 1'b1;
        nclk(4);

        // Randomized phase, checked by the model every cycle
        since_tick = 0;
        period = 12'd0;
        for (int i = 0; i < 5000; i++) begin
            tick_env  = ($urandom_range(0, 2) == 0);
            seed_load = ($urandom_range(0, 499) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
            since_tick++;
            tick_sample = 1'b0;
            if (since_tick >= 4 && $urandom_range(0, 3) == 0) begin
                tick_sample = 1'b1;
                pan         = 5'($urandom);
                amp_mode    = 1'($urandom);
                since_tick  = 0;
            end
            if ($urandom_range(0, 149) == 0) key_on = ~key_on;
            if ($urandom_range(0, 299) == 0) period = 12'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) tap_mask = 23'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                atk_rate = 4'($urandom_range(0, 2));
                dcy_rate = 4'($urandom_range(0, 2));
                rel_rate = 4'($urandom_range(0, 2));
                sus_lvl  = 6'($urandom);
            end
            nclk(1);
        end
        tick_sample = 0; tick_env = 0; seed_load = 0;
        nclk(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
